param_router: RTL

PARAM_ROUTER -- requirements
Module: param_router

---
 rtl/param_router.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/param_router.sv
// Source-routed single-phit crossbar: per-input FIFOs, per-output round-robin arbiters and output registers.
// Optional PARAM_ROUTER_DROP_EN selects drop-on-full flow control with a saturating drop counter.
module param_router #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned PW     = 18,
    parameter int unsigned RW     = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS*PW-1:0] in_data,
    input  logic [NPORTS-1:0]    in_valid,
    output logic [NPORTS-1:0]    in_ready,
    output logic [NPORTS*PW-1:0] out_data,
    output logic [NPORTS-1:0]    out_valid,
    input  logic [NPORTS-1:0]    out_ready,
    output logic [15:0]          drop_cnt
);
    localparam int unsigned DW = $clog2(NPORTS);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [PW-1:0]     mem_q  [NPORTS][DEPTH];
    logic [AW:0]       wptr_q [NPORTS];
    logic [AW:0]       wptr_d [NPORTS];
    logic [AW:0]       rptr_q [NPORTS];
    logic [AW:0]       rptr_d [NPORTS];
    logic [DW-1:0]     rr_q   [NPORTS];
    logic [DW-1:0]     rr_d   [NPORTS];
    logic [PW-1:0]     od_q   [NPORTS];
    logic [PW-1:0]     od_d   [NPORTS];
    logic [NPORTS-1:0] ov_q, ov_d;
    logic [NPORTS-1:0] full, empty, push, pop;
    logic [PW-1:0]     head   [NPORTS];

    // Consume this hop's destination: route field shifts up by DW, payload untouched.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
        logic [RW-1:0] rt;
        rt = p[PW-1 -: RW] << DW;
        return {rt, p[PW-RW-1:0]};
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NPORTS; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                       (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
            head[i]  = mem_q[i][rptr_q[i][AW-1:0]];
        end
    end

`ifdef PARAM_ROUTER_DROP_EN
    logic [NPORTS-1:0] drop;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [16:0]       drop_sum;

    always_comb begin
        in_ready = rst ? '0 : '1;
        push     = in_valid & ~full & in_ready;
        drop     = in_valid & full & in_ready;
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < NPORTS; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    always_comb begin
        in_ready = rst ? '0 : ~full;
        push     = in_valid & in_ready;
    end

    assign drop_cnt = '0;
`endif

    // Each input's head targets exactly one output, so at most one arbiter can pop it.
    always_comb begin
        logic          found;
        logic [DW-1:0] idx;
        pop   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned j = 0; j < NPORTS; j++) begin
            rr_d[j] = rr_q[j];
            od_d[j] = od_q[j];
            ov_d[j] = ov_q[j] && !out_ready[j];
            found   = 1'b0;
            if (!ov_q[j] || out_ready[j]) begin
                for (int unsigned off = 0; off < NPORTS; off++) begin
                    idx = rr_q[j] + DW'(off);
                    if (!found && !empty[idx] && (head[idx][PW-1 -: DW] == DW'(j))) begin
                        found    = 1'b1;
                        pop[idx] = 1'b1;
                        rr_d[j]  = idx + DW'(1);
                        ov_d[j]  = 1'b1;
                        od_d[j]  = advance(head[idx]);
                    end
                end
            end
        end
        for (int unsigned i = 0; i < NPORTS; i++) begin
            wptr_d[i] = wptr_q[i] + (AW+1)'(push[i]);
            rptr_d[i] = rptr_q[i] + (AW+1)'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i][AW-1:0]] <= in_data[i*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q <= '0;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                rr_q[i]   <= '0;
                od_q[i]   <= '0;
            end
        end else begin
            ov_q <= ov_d;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                rr_q[i]   <= rr_d[i];
                od_q[i]   <= od_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < NPORTS; j++) begin
            out_data[j*PW +: PW] = od_q[j];
        end
    end

    assign out_valid = ov_q;

endmodule
